nibble_serial_cla_subtractor: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor computing D = A - B, one 4-bit carry-lookahead

---
 rtl/nibble_serial_cla_subtractor.sv | 175 +++++++++++++++++
 tb/tb_nibble_serial_cla_subtractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_cla_subtractor.sv
// ---------------------------------------------------------------------------
// nibble_serial_cla_subtractor
//
// Purpose:
//   Multi-cycle WIDTH-bit subtractor computing d = a - b (modulo 2^WIDTH).
//   The subtraction is done as a + ~b + 1, one 4-bit carry-lookahead slice per
//   clock, with the slice carry-out chained into the next nibble. This trades
//   latency (WIDTH/4 cycles) for a much smaller adder than a flat lookahead.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b valid
//   in_ready   out  block can accept operands (IDLE)
//   a          in   minuend, sampled on in_valid & in_ready
//   b          in   subtrahend, sampled on in_valid & in_ready
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   d          out  difference a - b
//   borrow     out  1 when unsigned a < b (inverted final carry)
//   zero       out  1 when d == 0
//   ovf        out  two's-complement overflow flag
//
// Configuration:
//   OVF_FLAG_EN  when defined, ovf is computed and registered with the result;
//                when undefined, ovf is tied to 0 and no overflow logic exists.
// ---------------------------------------------------------------------------
module nibble_serial_cla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             zero_q;
    logic             inReady_q;
    logic             outValid_q;

    logic [CW+1:0]    nibIdx;
    logic [3:0]       sliceA;
    logic [3:0]       sliceB;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic [3:0]       carries;
    logic [3:0]       sliceSum;
    logic             lastNib;

    // One 4-bit lookahead slice on the nibble selected by the counter. The
    // subtrahend is inverted here; the +1 comes from carry_q being preset to 1
    // when an operation is accepted. diff_d is the full result vector with the
    // current nibble replaced, so zero can be judged on it in the last cycle.
    always_comb begin
        nibIdx   = {cnt_q, 2'b00};
        sliceA   = opA_q[nibIdx +: 4];
        sliceB   = ~opB_q[nibIdx +: 4];
        gen      = sliceA & sliceB;
        prop     = sliceA ^ sliceB;
        carries[0] = carry_q;
        carries[1] = gen[0] | (prop[0] & carry_q);
        carries[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_q);
        carries[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                   | (prop[2] & prop[1] & prop[0] & carry_q);
        carry_d    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0])
                   | (prop[3] & prop[2] & prop[1] & prop[0] & carry_q);
        sliceSum = prop ^ carries;
        diff_d   = diff_q;
        diff_d[nibIdx +: 4] = sliceSum;
        lastNib  = (cnt_q == CW'(NIB - 1));
    end

`ifdef OVF_FLAG_EN
    logic ovf_q;
`endif

    // Control FSM and all result registers. Flags are only updated on the
    // last nibble, so they keep the previous result through IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opA_q     <= a;
                        opB_q     <= b;
                        carry_q   <= 1'b1;
                        cnt_q     <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    diff_q  <= diff_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (lastNib) begin
                        borrow_q   <= ~carry_d;
                        zero_q     <= (diff_d == '0);
`ifdef OVF_FLAG_EN
                        ovf_q      <= (opA_q[WIDTH-1] ^ opB_q[WIDTH-1])
                                    & (opA_q[WIDTH-1] ^ diff_d[WIDTH-1]);
`endif
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign d         = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
`ifdef OVF_FLAG_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_cla_subtractor.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_cla_subtractor
//
// Purpose:
//   Directed and random checks of nibble_serial_cla_subtractor at WIDTH=16:
//   reset values, latency, carry chain, zero/borrow boundaries, backpressure
//   hold, reset abort mid-operation, overflow flag and a randomized run
//   against an a-b reference model.
//
// Ports: none (top-level bench). Honours OVF_FLAG_EN like the design.
// ---------------------------------------------------------------------------
module tb_nibble_serial_cla_subtractor;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             zero;
    logic             ovf;

    int checks   = 0;
    int passes   = 0;
    int failures = 0;

    nibble_serial_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts, asserts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one operation in, then wait (bounded) for out_valid.
    // Optionally wiggles out_ready randomly while waiting.
    task automatic applyStimulus(input logic [15:0] aV, input logic [15:0] bV,
                                 input bit randReady, output int latency);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        a        = aV;
        b        = bV;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~aV;
        b        = ~bV;
        latency  = 0;
        while (!out_valid && latency < 50) begin
            if (randReady) out_ready = 1'($urandom_range(0, 1));
            tick();
            latency++;
        end
        out_ready = 1'b0;
        if (latency >= 50) checkOutput("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [15:0] expD,
                               input logic expBorrow, input logic expZero, input logic expOvf);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_d"}, {16'd0, d}, {16'd0, expD});
        checkOutput({tag, "_borrow"}, {31'd0, borrow}, {31'd0, expBorrow});
        checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, expZero});
        checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expOvf});
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rd;
        logic        rovf;
        logic        ovfHi;

`ifdef OVF_FLAG_EN
        ovfHi = 1'b1;
`else
        ovfHi = 1'b0;
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_d", {16'd0, d}, 32'd0);
        checkOutput("rst_flags", {29'd0, borrow, zero, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic subtraction and latency
        applyStimulus(16'h1234, 16'h0234, 1'b0, lat);
        checkOutput("t1_latency", lat, 32'd4);
        checkResult("t1", 16'h1000, 1'b0, 1'b0, 1'b0);
        consume();

        // Full carry/borrow chain through all nibbles
        applyStimulus(16'h0000, 16'h0001, 1'b0, lat);
        checkOutput("t2_latency", lat, 32'd4);
        checkResult("t2", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        consume();

        // Equal operands plus 10 cycles of backpressure with a new request
        applyStimulus(16'hABCD, 16'hABCD, 1'b0, lat);
        checkResult("t3", 16'h0000, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("t3_hold_d", {16'd0, d}, 32'd0);
            checkOutput("t3_hold_zero", {31'd0, zero}, 32'd1);
            checkOutput("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        consume();
        checkOutput("t3_after_consume_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t3_after_consume_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t3_after_consume_d_held", {16'd0, d}, 32'd0);

        // 0 - max
        applyStimulus(16'h0000, 16'hFFFF, 1'b0, lat);
        checkResult("t4", 16'h0001, 1'b1, 1'b0, 1'b0);
        consume();

        // Reset during the second RUN cycle aborts the operation
        a        = 16'h1111;
        b        = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_abort_d", {16'd0, d}, 32'd0);
        checkOutput("t5_abort_borrow", {31'd0, borrow}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t5_release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t5_release_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, lat);
        checkOutput("t5_latency", lat, 32'd4);
        checkResult("t5", 16'h0E0E, 1'b0, 1'b0, 1'b0);
        consume();

        // Signed overflow cases
        applyStimulus(16'h8000, 16'h0001, 1'b0, lat);
        checkResult("t6", 16'h7FFF, 1'b0, 1'b0, ovfHi);
        consume();
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, lat);
        checkResult("t7", 16'h7FFE, 1'b0, 1'b0, 1'b0);
        consume();

        // Random operations with random backpressure
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = (($urandom_range(0, 15)) == 0) ? ra : 16'($urandom);
            rd = ra - rb;
`ifdef OVF_FLAG_EN
            rovf = (ra[15] != rb[15]) && (rd[15] != ra[15]);
`else
            rovf = 1'b0;
`endif
            applyStimulus(ra, rb, 1'b1, lat);
            checkOutput("rnd_latency", lat, 32'd4);
            checkResult("rnd", rd, (ra < rb), (ra == rb), rovf);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                tick();
                checkOutput("rnd_hold_d", {16'd0, d}, {16'd0, rd});
            end
            consume();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
